// File: rtl/axis_pkg.sv
// ============================================================================
// Module : axis_pkg
// Brief  : State encoding, 100 MHz timing defaults and helpers for axis_step_gen.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axis_pkg;

    localparam int c_PULSE_CYC_100M      = 200;
    localparam int c_DIR_SETUP_CYC_100M  = 500;
    localparam int c_MIN_PERIOD_CYC_100M = 1000;
    localparam int c_TMR_W               = 32;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DIR_SETUP = 2'd1,
        S_STEP_HIGH = 2'd2,
        S_STEP_LOW  = 2'd3
    } axis_state_e;

    // Requested period clamped up to the driver's minimum step period.
    function automatic logic [c_TMR_W-1:0] eff_period(input logic [c_TMR_W-1:0] period,
                                                      input int min_cyc);
        return (period < c_TMR_W'(min_cyc)) ? c_TMR_W'(min_cyc) : period;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_step_gen_if.sv
// ============================================================================
// Module : axis_step_gen_if
// Brief  : Move-request / STEP-DIR bundle between regfile wrapper and one axis.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface axis_step_gen_if #(
    parameter int POS_W = 32
);
    logic                    move_fwd;
    logic                    move_rev;
    logic [31:0]             period;
    logic                    zero_pos;
    logic                    step;
    logic                    dir;
    logic signed [POS_W-1:0] position;
    logic                    busy;
    logic                    limit_hit;

    modport master (
        output move_fwd, move_rev, period, zero_pos,
        input  step, dir, position, busy, limit_hit
    );

    modport slave (
        input  move_fwd, move_rev, period, zero_pos,
        output step, dir, position, busy, limit_hit
    );
endinterface

`default_nettype wire

// File: rtl/axis_step_gen_step_timer.sv
// ============================================================================
// Module : step_timer
// Brief  : Loadable down-counter; o_done is high while the count sits at zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module step_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/axis_step_gen.sv
// ============================================================================
// Module : axis_step_gen
// Brief  : Single-axis STEP/DIR generator with step-accurate position count.
//          Optional soft limits enabled by defining AXIS_LIMIT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axis_step_gen
    import axis_pkg::*;
#(
    parameter int PULSE_CYC      = c_PULSE_CYC_100M,
    parameter int DIR_SETUP_CYC  = c_DIR_SETUP_CYC_100M,
    parameter int MIN_PERIOD_CYC = c_MIN_PERIOD_CYC_100M,
    parameter int POS_W          = 32,
    parameter int POS_MIN        = -100000,
    parameter int POS_MAX        = 100000
) (
    input  logic           clock,
    input  logic           reset,
    axis_step_gen_if.slave bus
);
    axis_state_e          r_state;
    axis_state_e          w_state_nxt;
    logic                 r_dir;
    logic                 r_step;
    logic [POS_W-1:0]     r_pos;
    logic [c_TMR_W-1:0]   r_eff;
    logic [c_TMR_W-1:0]   w_eff;
    logic [c_TMR_W-1:0]   w_tmr_val;
    logic                 w_req_valid;
    logic                 w_req_dir;
    logic                 w_blocked;
    logic                 w_go;
    logic                 w_same_dir;
    logic                 w_tmr_load;
    logic                 w_tmr_done;
    logic                 w_rise;
    logic                 w_dir_load;

    if (MIN_PERIOD_CYC < 2 * PULSE_CYC || PULSE_CYC < 1 || DIR_SETUP_CYC < 1 ||
        POS_MIN >= POS_MAX) begin : g_param_err
        $error("axis_step_gen: inconsistent timing or limit parameters");
    end

    assign w_req_valid = (bus.move_fwd ^ bus.move_rev) && (bus.period != '0);
    assign w_req_dir   = bus.move_fwd;
    assign w_eff       = eff_period(bus.period, MIN_PERIOD_CYC);

`ifdef AXIS_LIMIT_EN
    localparam logic signed [POS_W-1:0] c_POS_MIN = POS_W'(POS_MIN);
    localparam logic signed [POS_W-1:0] c_POS_MAX = POS_W'(POS_MAX);

    // A step is refused only if it would carry position past the limit.
    assign w_blocked     = w_req_valid && (w_req_dir ? ($signed(r_pos) >= c_POS_MAX)
                                                     : ($signed(r_pos) <= c_POS_MIN));
    assign bus.limit_hit = w_blocked && (r_state == S_IDLE);
`else
    assign w_blocked     = 1'b0;
    assign bus.limit_hit = 1'b0;
`endif

    assign w_go       = w_req_valid && !w_blocked;
    assign w_same_dir = (w_req_dir == r_dir);

    step_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk     (clock),
        .rst_n   (reset),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_done  (w_tmr_done)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) w_state_nxt = w_same_dir ? S_STEP_HIGH : S_DIR_SETUP;
            end
            S_DIR_SETUP: begin
                if (w_tmr_done) w_state_nxt = S_STEP_HIGH;
            end
            S_STEP_HIGH: begin
                if (w_tmr_done) w_state_nxt = S_STEP_LOW;
            end
            S_STEP_LOW: begin
                if (w_tmr_done) begin
                    if (w_go) w_state_nxt = w_same_dir ? S_STEP_HIGH : S_DIR_SETUP;
                    else      w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Timer is reloaded on every state change with (phase length - 1).
    always_comb begin
        w_tmr_load = (w_state_nxt != r_state);
        w_rise     = (w_state_nxt == S_STEP_HIGH) && (r_state != S_STEP_HIGH);
        w_dir_load = (w_state_nxt == S_DIR_SETUP) && (r_state != S_DIR_SETUP);
        case (w_state_nxt)
            S_DIR_SETUP: w_tmr_val = c_TMR_W'(DIR_SETUP_CYC - 1);
            S_STEP_HIGH: w_tmr_val = c_TMR_W'(PULSE_CYC - 1);
            S_STEP_LOW:  w_tmr_val = r_eff - c_TMR_W'(PULSE_CYC + 1);
            default:     w_tmr_val = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dir  <= 1'b0;
            r_step <= 1'b0;
            r_pos  <= '0;
            r_eff  <= '0;
        end else begin
            r_step <= (w_state_nxt == S_STEP_HIGH);
            if (w_dir_load) r_dir <= w_req_dir;
            if (w_rise)     r_eff <= w_eff;
            if (bus.zero_pos) begin
                r_pos <= '0;
            end else if (w_rise) begin
                r_pos <= r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
            end
        end
    end

    assign bus.step     = r_step;
    assign bus.dir      = r_dir;
    assign bus.position = r_pos;
    assign bus.busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_axis_step_gen.sv
// ============================================================================
// Module : tb_axis_step_gen
// Brief  : Directed + random checks of axis_step_gen against a timestamp model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axis_step_gen;
    localparam int P    = 2;
    localparam int S    = 3;
    localparam int M    = 6;
    localparam int PW   = 32;
    localparam int PMIN = -3;
    localparam int PMAX = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_step_gen_if #(.POS_W(PW)) bus ();

    axis_step_gen #(
        .PULSE_CYC      (P),
        .DIR_SETUP_CYC  (S),
        .MIN_PERIOD_CYC (M),
        .POS_W          (PW),
        .POS_MIN        (PMIN),
        .POS_MAX        (PMAX)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: event timestamps (edge numbers) rather than a state register.
    longint k = 0, last_rise = -1000, next_dec = -1, forced = -1;
    bit m_idle = 1'b1, m_dir = 1'b0;
    logic signed [31:0] m_pos = '0;

    // Observed-side bookkeeping for directed measurements.
    int     n_rise = 0, n_high = 0;
    longint rise_k = 0, dirfall_k = 0;
    bit     prev_step = 1'b0, prev_dir = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit blocked(input bit go, input bit rd, input logic signed [31:0] pos);
`ifdef AXIS_LIMIT_EN
        return go && (rd ? (pos >= PMAX) : (pos <= PMIN));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        bit go, rd, rise;
        longint eff;
        k++;
        if (!rst_n) begin
            m_idle = 1'b1; m_dir = 1'b0; m_pos = '0;
            last_rise = -1000; forced = -1; next_dec = -1;
            return;
        end
        go   = (bus.move_fwd ^ bus.move_rev) && (bus.period != 0);
        rd   = bus.move_fwd;
        go   = go && !blocked(go, rd, m_pos);
        rise = 1'b0;
        if (forced == k) begin
            rise = 1'b1; forced = -1;
        end else if (m_idle || k == next_dec) begin
            if (!go)              m_idle = 1'b1;
            else if (rd == m_dir) rise = 1'b1;
            else begin
                m_dir = rd; forced = k + S; m_idle = 1'b0;
            end
        end
        if (rise) begin
            eff       = (bus.period < M) ? M : longint'(bus.period);
            last_rise = k;
            next_dec  = k + eff;
            m_idle    = 1'b0;
            m_pos     = m_pos + (m_dir ? 1 : -1);
        end
        if (bus.zero_pos) m_pos = '0;
    endtask

    task automatic cyc();
        bit go;
        @(posedge clk);
        model_edge();
        #1;
        go = (bus.move_fwd ^ bus.move_rev) && (bus.period != 0);
        check("step", bus.step, ((k - last_rise) < P) ? 1 : 0);
        check("dir", bus.dir, m_dir);
        check("pos", longint'($signed(bus.position)), longint'(m_pos));
        check("busy", bus.busy, !m_idle);
        check("limit", bus.limit_hit, (rst_n && m_idle && blocked(go, bus.move_fwd, m_pos)) ? 1 : 0);
        if (bus.step && !prev_step) begin n_rise++; rise_k = k; end
        if (bus.step) n_high++;
        if (prev_dir && !bus.dir) dirfall_k = k;
        prev_step = bus.step;
        prev_dir  = bus.dir;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_rise(input string tag, input int max_cyc);
        int r;
        int i;
        r = n_rise;
        i = 0;
        while (n_rise == r && i < max_cyc) begin cyc(); i++; end
        check(tag, n_rise - r, 1);
    endtask

    initial begin
        int r0, h0, seg, sel;
        logic signed [31:0] p0;
        longint k1;
        bus.move_fwd = 0; bus.move_rev = 0; bus.period = 10; bus.zero_pos = 0;
        run(3);
        check("rst_step", bus.step, 0);
        check("rst_dir", bus.dir, 0);
        check("rst_pos", bus.position, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_limit", bus.limit_hit, 0);
        rst_n = 1'b1;

`ifdef AXIS_LIMIT_EN
        r0 = n_rise;
        bus.move_fwd = 1; bus.period = 6;
        run(80);
        check("lim_pulses", n_rise - r0, 3);
        check("lim_pos", $signed(bus.position), 3);
        check("lim_hit_set", bus.limit_hit, 1);
        bus.move_fwd = 0;
        cyc();
        check("lim_hit_clr", bus.limit_hit, 0);
        bus.move_rev = 1; cyc(); bus.move_rev = 0;
        run(15);
        check("lim_rev_pos", $signed(bus.position), 2);
        check("lim_rev_hit", bus.limit_hit, 0);
`else
        // Steady forward at period 10 after the initial direction change.
        bus.move_fwd = 1;
        wait_rise("fwd_first_rise", 20);
        r0 = n_rise; h0 = n_high; p0 = bus.position;
        run(49);
        check("fwd_pulses_50", n_rise - r0 + 1, 5);
        check("fwd_high_50", n_high - h0 + 1, 10);
        check("fwd_pos_delta", $signed(bus.position) - p0, 4);

        // Reversal: dir falls, then step rises S cycles later.
        p0 = bus.position;
        bus.move_fwd = 0; bus.move_rev = 1;
        wait_rise("rev_rise", 30);
        check("rev_setup", rise_k - dirfall_k, S);
        check("rev_pos", $signed(bus.position), p0 - 1);

        // Period clamp, then stop.
        bus.period = 1;
        wait_rise("clamp_r1", 20);
        k1 = rise_k;
        wait_rise("clamp_r2", 20);
        check("clamp_period", rise_k - k1, M);
        bus.period = 0;
        r0 = n_rise;
        for (int i = 0; i < 20 && bus.busy; i++) cyc();
        check("stop_busy", bus.busy, 0);
        check("stop_no_rise", n_rise - r0, 0);

        // Request dropped during STEP_HIGH.
        r0 = n_rise; h0 = n_high; p0 = bus.position;
        bus.period = 8;
        cyc();
        bus.move_rev = 0;
        run(12);
        check("drop_pulses", n_rise - r0, 1);
        check("drop_high", n_high - h0, 2);
        check("drop_pos", $signed(bus.position), p0 - 1);
        check("drop_busy", bus.busy, 0);

        // Conflicting request.
        r0 = n_rise;
        bus.move_fwd = 1; bus.move_rev = 1;
        run(30);
        check("conflict_pulses", n_rise - r0, 0);
        check("conflict_busy", bus.busy, 0);

        // zero_pos coincident with the rise that would take position 7 -> 8.
        bus.move_rev = 0; bus.period = 6;
        cyc();
        bus.move_fwd = 0;
        run(20);
        bus.zero_pos = 1; cyc(); bus.zero_pos = 0;
        bus.move_fwd = 1;
        run(42);
        check("zero_pre_pos", $signed(bus.position), 7);
        bus.zero_pos = 1; cyc(); bus.zero_pos = 0;
        check("zero_step", bus.step, 1);
        check("zero_pos", $signed(bus.position), 0);

        // Reset mid STEP_HIGH.
        rst_n = 1'b0; bus.move_fwd = 0;
        cyc();
        check("midrst_step", bus.step, 0);
        check("midrst_pos", bus.position, 0);
        check("midrst_busy", bus.busy, 0);
        rst_n = 1'b1;
`endif

        // Randomized segments of held requests.
        seg = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                seg = int'($urandom_range(1, 40));
                sel = int'($urandom_range(0, 9));
                bus.move_fwd = (sel <= 3) || (sel == 7);
                bus.move_rev = (sel >= 4 && sel <= 7);
                case ($urandom_range(0, 4))
                    0:       bus.period = 0;
                    1:       bus.period = 1;
                    2:       bus.period = M;
                    3:       bus.period = M + 1;
                    default: bus.period = $urandom_range(0, 30);
                endcase
            end
            seg--;
            bus.zero_pos = ($urandom_range(0, 99) == 0);
            rst_n        = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/axis_step_gen.md
Name: axis_step_gen

Overview:
- Single-axis step/direction pulse generator for the pen-plotter XY stage.
- Consumes the per-axis move request levels (move forward / move reverse) and the speed register value produced by the top-level wrapper/regfile.
- Drives the external stepper-driver STEP/DIR pins with guaranteed pulse width, direction setup time and minimum step period.
- Maintains a true step-accurate position count, replacing the per-clock position increment. Two instances are used, one for X and one for Y.

Parameters:
- PULSE_CYC, 200, STEP high time in clocks (2 us at 100 MHz).
- DIR_SETUP_CYC, 500, clocks DIR must be stable before a STEP rising edge after a direction change.
- MIN_PERIOD_CYC, 1000, minimum clocks between STEP rising edges; must be >= 2*PULSE_CYC.
- POS_W, 32, position counter width (two's complement).
- POS_MIN, -100000, lower soft limit (used only with AXIS_LIMIT_EN).
- POS_MAX, 100000, upper soft limit (used only with AXIS_LIMIT_EN).

Ports:
- clock  in  1  system clock (CLK100MHZ domain).
- reset  in  1  synchronous, active-low reset.
- move_fwd  in  1  level request: step in + direction.
- move_rev  in  1  level request: step in - direction.
- period  in  32  requested clocks between STEP rising edges (speed register); 0 = stop.
- zero_pos  in  1  synchronous position clear (BTNC).
- step  out  1  STEP pin.
- dir  out  1  DIR pin; 1 = forward.
- position  out  POS_W  signed step count.
- busy  out  1  high in any state other than IDLE.
- limit_hit  out  1  soft-limit block indicator; tied 0 when AXIS_LIMIT_EN is undefined.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, step=0, dir=0, position=0, busy=0, limit_hit=0, timers=0.
- Valid request: exactly one of move_fwd/move_rev high AND period!=0.
  - Both high, or period==0, counts as no request.
  - req_dir = move_fwd.
- Effective period: eff = max(period, MIN_PERIOD_CYC). It is latched on entry to STEP_HIGH and held constant for that step.
- States and transitions:
  - IDLE: step=0.
    - Valid request with req_dir==dir -> STEP_HIGH next cycle.
    - Valid request with req_dir!=dir -> dir<=req_dir, go to DIR_SETUP.
  - DIR_SETUP: count DIR_SETUP_CYC cycles, then -> STEP_HIGH. Request changes during setup are ignored; the setup always completes.
  - STEP_HIGH: step=1 for exactly PULSE_CYC cycles, then -> STEP_LOW.
    - position updates by +1/-1 (per dir) in the same cycle step first goes high.
  - STEP_LOW: step=0 for eff-PULSE_CYC cycles, then re-evaluate:
    - same-dir valid request -> STEP_HIGH;
    - opposite-dir valid request -> DIR_SETUP, with dir updated;
    - no request -> IDLE.
- Latency:
  - IDLE request sampled at edge N with no direction change gives step=1 at N+1.
  - With a direction change, dir toggles at N+1 and step=1 at N+1+DIR_SETUP_CYC.
- A started step is never truncated. Dropping the request mid-pulse completes STEP_HIGH and STEP_LOW before returning to IDLE.
- zero_pos: position<=0 and has priority over a same-cycle increment. Motion is not aborted.
- position wraps modulo 2^POS_W (no saturation) when AXIS_LIMIT_EN is undefined.
- Reset asserted mid-step forces IDLE and step=0 on the next edge. The pulse may be short; this is accepted.

Optional Feature:
- Macro: AXIS_LIMIT_EN.
- Defined:
  - A step that would move position above POS_MAX or below POS_MIN is not issued. The FSM stays in IDLE (or goes to IDLE from STEP_LOW), and limit_hit=1 while such a request is held.
  - The opposite direction remains allowed.
  - limit_hit clears the cycle the blocking request drops.
- Undefined: no limit checks; limit_hit is constant 0.

Decomposition:
- Package axis_pkg: state enum (IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW) and the default timing constants for 100 MHz.
- One sub-module, step_timer: a loadable down-counter with a done flag, reused for the setup, high and low phases.

Test Plan (bench params PULSE_CYC=2, DIR_SETUP_CYC=3, MIN_PERIOD_CYC=6):
- Steady forward: move_fwd=1, period=10 held from reset, dir already 1 after one prior step. Required: step high 2 clocks every 10 clocks; position increments 1 per rising edge; 5 pulses in 50 clocks.
- Direction reversal: after forward stepping, switch to move_rev=1. Required: dir falls, no step for 3 clocks, then step rises; position decrements.
- Period clamp and stop: period=1 -> pulses every 6 clocks. period=0 -> return to IDLE after the current step completes; busy=0.
- Mid-step drop and conflict: drop move_fwd during STEP_HIGH -> full 2-cycle pulse plus remaining low time, exactly one increment. move_fwd=move_rev=1 -> no pulses.
- zero_pos coincident with step rise at position=7: required position=0, not 8. Reset low mid-STEP_HIGH -> step=0 and position=0 next edge.
- AXIS_LIMIT_EN with POS_MAX=3: forward from 0 gives exactly 3 pulses, then limit_hit=1 and no further steps. move_rev then steps to 2 and limit_hit=0.
